fetch_stage: RTL
================

# fetch_stage

Instruction-fetch stage of the 5-stage RV32I pipeline, directly upstream of the decode stage. Holds the PC, issues one-outstanding-request fetches to instruction memory over a grant/valid handshake, and owns the IF/ID pipeline register that drives `InstrD`, `PCD` and `PCPlus4D` into decode. Honours hazard-unit stall/flush and execute-stage redirects, and inserts NOP bubbles while memory is slow.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC after reset.
- `NOP_INSTR`, default 32'h0000_0013 (`addi x0,x0,0`): bubble instruction.

- `clk`  input  1  sole clock; all state updates on the rising edge.
- `rst`  input  1  synchronous, active-low reset; sampled on the rising edge of `clk`.
- `StallF`  input  1  hazard unit: freeze PC and block new requests.
- `StallD`  input  1  hazard unit: hold the IF/ID register.
- `FlushD`  input  1  hazard unit: load a bubble into IF/ID.
- `PCSrcE`  input  1  execute stage: taken branch or jump.
- `PCTargetE`  input  32  redirect target, word aligned.
- `imem_req`  output  1  fetch request valid.
- `imem_addr`  output  32  fetch address.
- `imem_gnt`  input  1  memory accepts the request this cycle.
- `imem_rvalid`  input  1  response valid; exactly one per granted request, at least 1 cycle after grant.
- `imem_rdata`  input  32  instruction word.
- `InstrD`, `PCD`, `PCPlus4D`  output  32 each  IF/ID register contents.
- `ValidD`  output  1  IF/ID holds a real instruction (0 = bubble).

## Operation
- Registers: `PCF`, FSM state, `kill` flag, hold buffer (instr + PC), IF/ID register.
- States:
  - REQ: `imem_req = !StallF`, `imem_addr = PCF`. On grant, go to WAIT.
  - WAIT: one request is outstanding at address `PCF`.
  - HOLD: response buffered; decode is stalled.
- WAIT, on `imem_rvalid`:
  - If `kill`: discard the response, clear `kill`, go to REQ.
  - Else if `!StallD`: IF/ID ← {`imem_rdata`, `PCF`, `PCF+4`, `ValidD=1`} and `PCF` ← `PCF+4`.
    - Back-to-back issue in the same cycle: `imem_req = !StallF`, `imem_addr = PCF+4`. On grant stay in WAIT; otherwise go to REQ.
  - Else (`StallD`): buffer the response and go to HOLD. No request is issued.
- HOLD: no requests. When `!StallD`: IF/ID ← buffer, `PCF` ← `PCF+4`, go to REQ.
- Bubbles: if `!StallD` and no instruction is delivered this cycle, IF/ID ← {`NOP_INSTR`, 0, 0, `ValidD=0`}.
- `StallD`: IF/ID holds its value unless `FlushD` is asserted.
- `FlushD`: IF/ID ← bubble. Overrides `StallD` and any delivery; a response consumed in that cycle is lost only when `PCSrcE` is also asserted.
- `PCSrcE` (priority over `StallF` and normal PC update):
  - `PCF` ← `PCTargetE` and the hold buffer is dropped.
  - Next state REQ, except WAIT with the in-flight response not returning this cycle, or a request granted this cycle. In those cases next state is WAIT with `kill` ← 1.
  - A response returning in the redirect cycle is discarded and never loaded into IF/ID.
- Arithmetic: `PCPlus4` is 32-bit modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.

## Timing
- Reset (`rst` = 0 at a clock edge):
  - `PCF = RESET_PC`, state REQ, `kill = 0`, buffer empty.
  - `InstrD = NOP_INSTR`, `PCD = 0`, `PCPlus4D = 0`, `ValidD = 0`.
  - `imem_req` is forced to 0 while `rst` = 0. Responses during reset are ignored.
  - The instruction memory shares `rst`, so no pre-reset response arrives after reset.
- First request is issued in the first cycle with `rst` = 1.
- Latency: grant at cycle n with rvalid at n+1 puts the instruction on `InstrD` at n+2.
- Throughput: 1 instruction/cycle with 1-cycle memory and continuous grant. Otherwise 1 per (response latency) cycles.
- `imem_addr` is stable while `imem_req` = 1 and not granted, except on a `PCSrcE` redirect.
- No combinational path from `imem_rdata` to any output. `imem_req`/`imem_addr` may depend combinationally on `imem_rvalid`, `StallF`, `StallD`, `PCSrcE`.

## Test plan
- Reset then run, with 1-cycle memory and `gnt` = 1: `PCD` shows 0x0, 0x4, 0x8, 0xC on consecutive cycles from cycle 2, `ValidD` = 1 throughout. During reset `InstrD` = 0x00000013 and `ValidD` = 0.
- 3-cycle response latency: `ValidD` pattern is 1,0,0 repeating. `imem_addr` advances by 4 per response, and bubbles carry `NOP_INSTR`.
- `StallD` held for 3 cycles while a response (0xDEADBEEF at PC 0x10) arrives: IF/ID is frozen, state goes to HOLD, no `imem_req`. On release `InstrD` = 0xDEADBEEF with `PCD` = 0x10, then the next fetch is at 0x14.
- `PCSrcE` = 1 with `PCTargetE` = 0x100 while a request to 0x20 is in flight with 2-cycle latency: the 0x20 response is discarded and never reaches `InstrD`. The next `imem_addr` = 0x100, and `PCD` = 0x100 is the next valid instruction.
- `FlushD` together with `StallD`: IF/ID becomes a bubble (`ValidD` = 0).
- `rst` low mid-WAIT: the next cycle `PCF` = `RESET_PC` and `ValidD` = 0. A stray rvalid during reset has no effect.
- PC wrap: set `PCTargetE` = 0xFFFFFFFC; `PCPlus4D` = 0x0 and the next `imem_addr` = 0x0.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, single-outstanding imem fetch FSM,
// one-entry response buffer for decode stalls, and the IF/ID pipeline register.
module fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        StallF,
   input  logic        StallD,
   input  logic        FlushD,
   input  logic        PCSrcE,
   input  logic [31:0] PCTargetE,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] InstrD,
   output logic [31:0] PCD,
   output logic [31:0] PCPlus4D,
   output logic        ValidD
);

   typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

   state_t      state_q, state_d;
   logic [31:0] pcf_q, pcf_d;
   logic        kill_q, kill_d;
   logic [31:0] hold_instr_q, hold_instr_d;
   logic [31:0] hold_pc_q, hold_pc_d;
   logic [31:0] ifid_instr_q, ifid_instr_d;
   logic [31:0] ifid_pc_q, ifid_pc_d;
   logic [31:0] ifid_pc4_q, ifid_pc4_d;
   logic        ifid_valid_q, ifid_valid_d;

   logic        req;
   logic        take;
   logic        deliver;
   logic [31:0] dl_instr;
   logic [31:0] dl_pc;
   logic [31:0] pcf_plus4;

   assign pcf_plus4 = pcf_q + 32'd4;
   // Decode can only accept an instruction when it is neither stalled nor flushed.
   assign take      = !StallD && !FlushD;

   // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latches).
   always_comb begin
      state_d      = state_q;
      pcf_d        = pcf_q;
      kill_d       = kill_q;
      hold_instr_d = hold_instr_q;
      hold_pc_d    = hold_pc_q;
      req          = 1'b0;
      imem_addr    = pcf_q;
      deliver      = 1'b0;
      dl_instr     = hold_instr_q;
      dl_pc        = hold_pc_q;

      case (state_q)
         S_REQ: begin
            req = !StallF;
            if (req && imem_gnt) state_d = S_WAIT;
         end
         S_WAIT: begin
            if (imem_rvalid) begin
               if (kill_q) begin
                  kill_d  = 1'b0;
                  state_d = S_REQ;
               end else if (take && !PCSrcE) begin
                  deliver   = 1'b1;
                  dl_instr  = imem_rdata;
                  dl_pc     = pcf_q;
                  pcf_d     = pcf_plus4;
                  req       = !StallF;
                  imem_addr = pcf_plus4;
                  state_d   = (req && imem_gnt) ? S_WAIT : S_REQ;
               end else if (!PCSrcE) begin
                  hold_instr_d = imem_rdata;
                  hold_pc_d    = pcf_q;
                  state_d      = S_HOLD;
               end
            end
         end
         S_HOLD: begin
            if (take) begin
               deliver = 1'b1;
               pcf_d   = pcf_plus4;
               state_d = S_REQ;
            end
         end
         default: state_d = S_REQ;
      endcase

      // A redirect squashes any delivery; an in-flight or just-granted fetch is killed.
      if (PCSrcE) begin
         pcf_d   = PCTargetE;
         deliver = 1'b0;
         if ((state_q == S_WAIT && !imem_rvalid) || (req && imem_gnt)) begin
            state_d = S_WAIT;
            kill_d  = 1'b1;
         end else begin
            state_d = S_REQ;
            kill_d  = 1'b0;
         end
      end
   end

   assign imem_req = req && rst;

   always_comb begin
      ifid_instr_d = ifid_instr_q;
      ifid_pc_d    = ifid_pc_q;
      ifid_pc4_d   = ifid_pc4_q;
      ifid_valid_d = ifid_valid_q;
      if (FlushD || (!StallD && !deliver)) begin
         ifid_instr_d = NOP_INSTR;
         ifid_pc_d    = 32'd0;
         ifid_pc4_d   = 32'd0;
         ifid_valid_d = 1'b0;
      end else if (!StallD) begin
         ifid_instr_d = dl_instr;
         ifid_pc_d    = dl_pc;
         ifid_pc4_d   = dl_pc + 32'd4;
         ifid_valid_d = 1'b1;
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= S_REQ;
         pcf_q        <= RESET_PC;
         kill_q       <= 1'b0;
         hold_instr_q <= 32'd0;
         hold_pc_q    <= 32'd0;
         ifid_instr_q <= NOP_INSTR;
         ifid_pc_q    <= 32'd0;
         ifid_pc4_q   <= 32'd0;
         ifid_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         pcf_q        <= pcf_d;
         kill_q       <= kill_d;
         hold_instr_q <= hold_instr_d;
         hold_pc_q    <= hold_pc_d;
         ifid_instr_q <= ifid_instr_d;
         ifid_pc_q    <= ifid_pc_d;
         ifid_pc4_q   <= ifid_pc4_d;
         ifid_valid_q <= ifid_valid_d;
      end
   end

   assign InstrD   = ifid_instr_q;
   assign PCD      = ifid_pc_q;
   assign PCPlus4D = ifid_pc4_q;
   assign ValidD   = ifid_valid_q;

endmodule
